dff_ram_72x8: RTL and testbench

//  Flip-flop based single-port RAM: 8 words x 72 bits, synchronous write,

---
 rtl/dff_ram_72x8.sv | 77 +++++++
 tb/tb_dff_ram_72x8.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dff_ram_72x8.sv
// -----------------------------------------------------------------------------
// dff_ram_72x8
// Flip-flop based single-port RAM, 8 words x 72 bits. Writes are synchronous.
// Reads are registered: data_out shows the addressed word one rising edge
// after the read is sampled. Enable and write strobe are both active low.
// The store is built from plain DFFs so it can be used as a small register
// file in the ASIC flow without a memory macro.
//
// Ports
//   clk       in   1           single clock, all state on rising edge
//   rst       in   1           asynchronous active-high reset, clears
//                              every word and data_out
//   address   in   ADDR_WIDTH  word select for read and write
//   en        in   1           chip enable, active low (0 = selected)
//   wr        in   1           write strobe, active low (0 = write, 1 = read)
//   data_in   in   DATA_WIDTH  write data
//   data_out  out  DATA_WIDTH  registered read data, holds between reads
// -----------------------------------------------------------------------------
module dff_ram_72x8 #(
   parameter int DATA_WIDTH = 72,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  en,
   input  logic                  wr,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] data_out_r;
   logic                  wr_en_s;
   logic                  rd_en_s;

   // Decode the active-low enable/strobe pair into one-hot write/read requests.
   always_comb begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
      if (en == 1'b0) begin
         if (wr == 1'b0) begin
            wr_en_s = 1'b1;
         end else begin
            rd_en_s = 1'b1;
         end
      end else begin
         wr_en_s = 1'b0;
         rd_en_s = 1'b0;
      end
   end

   // Storage array: async clear, otherwise write the addressed word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else if (wr_en_s) begin
         mem_r[address] <= data_in;
      end
   end

   // Read register: samples the pre-edge word on a read, otherwise holds.
   // Writes never pass through to data_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_r <= {DATA_WIDTH{1'b0}};
      end else if (rd_en_s) begin
         data_out_r <= mem_r[address];
      end
   end

   assign data_out = data_out_r;

endmodule

// File: tb/tb_dff_ram_72x8.sv
// -----------------------------------------------------------------------------
// tb_dff_ram_72x8
// Self-checking bench for dff_ram_72x8: directed scenarios followed by a
// randomized phase, all checked against a word-array reference model.
// -----------------------------------------------------------------------------
module tb_dff_ram_72x8;

   logic        clk;
   logic        rst;
   logic [2:0]  address;
   logic        en;
   logic        wr;
   logic [71:0] data_in;
   logic [71:0] data_out;

   int checks = 0;
   int errors = 0;

   // reference model: the words and the last value read out
   logic [71:0] model_mem [8];
   logic [71:0] model_out;

   localparam logic [71:0] VAL_A = 72'h123456789ABCDEF012;
   localparam logic [71:0] VAL_B = 72'h89ABCDEF0121234567;
   localparam logic [71:0] ONES  = {72{1'b1}};

   dff_ram_72x8 dut (
      .clk      (clk),
      .rst      (rst),
      .address  (address),
      .en       (en),
      .wr       (wr),
      .data_in  (data_in),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) model_mem[i] = 72'h0;
      model_out = 72'h0;
   endtask

   // drive one operation from a negedge, apply it to the model at the
   // rising edge, compare data_out at the following negedge
   task automatic step(input logic e, input logic w, input logic [2:0] a,
                       input logic [71:0] d, input string tag);
      en = e; wr = w; address = a; data_in = d;
      @(posedge clk);
      if (e == 1'b0 && w == 1'b0) model_mem[a] = d;
      else if (e == 1'b0 && w == 1'b1) model_out = model_mem[a];
      @(negedge clk);
      chk(tag, data_out, model_out);
   endtask

   function automatic logic [71:0] rand72();
      logic [71:0] v;
      v = {8'($urandom), 32'($urandom), 32'($urandom)};
      return v;
   endfunction

   initial begin
      rst = 1'b1; en = 1'b1; wr = 1'b1; address = 3'd0; data_in = 72'h0;
      model_clear();

      // 1. reset state
      repeat (2) @(negedge clk);
      chk("reset_out", data_out, 72'h0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 3'(i), 72'h0, "t1_read_model");
         chk("t1_read_zero", data_out, 72'h0);
      end

      // 2. write then read address 4
      step(1'b0, 1'b0, 3'd4, VAL_A, "t2_write");
      step(1'b0, 1'b1, 3'd4, 72'h0, "t2_read");
      chk("t2_read_const", data_out, VAL_A);

      // 3. second word, first word intact
      step(1'b0, 1'b0, 3'd3, VAL_B, "t3_write");
      step(1'b0, 1'b1, 3'd3, 72'h0, "t3_read3");
      chk("t3_read3_const", data_out, VAL_B);
      step(1'b0, 1'b1, 3'd4, 72'h0, "t3_read4");
      chk("t3_read4_const", data_out, VAL_A);

      // 4. disabled write is ignored, data_out holds while idle
      step(1'b1, 1'b0, 3'd4, ONES, "t4_disabled");
      chk("t4_hold_const", data_out, VAL_A);
      step(1'b0, 1'b1, 3'd4, 72'h0, "t4_read");
      chk("t4_read_const", data_out, VAL_A);

      // inputs that toggle between edges are not sampled
      en = 1'b0; wr = 1'b0; address = 3'd5; data_in = ONES;
      #2;
      en = 1'b1; wr = 1'b1;
      step(1'b1, 1'b1, 3'd5, ONES, "glitch_idle");
      step(1'b0, 1'b1, 3'd5, 72'h0, "glitch_read");
      chk("glitch_read_const", data_out, 72'h0);

      // 5. write after read: data_out keeps A until the next read
      step(1'b0, 1'b0, 3'd2, VAL_A, "t5_writeA");
      step(1'b0, 1'b1, 3'd2, 72'h0, "t5_readA");
      step(1'b0, 1'b0, 3'd2, VAL_B, "t5_writeB");
      chk("t5_hold_const", data_out, VAL_A);
      step(1'b0, 1'b1, 3'd2, 72'h0, "t5_readB");
      chk("t5_readB_const", data_out, VAL_B);

      // 6. asynchronous reset pulse in the middle of a write burst
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'(i), rand72(), "t6_burst");
      en = 1'b0; wr = 1'b0; address = 3'd5; data_in = rand72();
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_clear", data_out, 72'h0);
      model_clear();
      en = 1'b1;
      #1;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 3'(i), 72'h0, "t6_read_model");
         chk("t6_read_zero", data_out, 72'h0);
      end

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)),
              rand72(), "rand_op");
      end

      // final readback of every word
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 72'h0, "final_read");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
